// File: rtl/snn_step_scheduler.sv
// Timestep sequencer: arms the pre-synaptic buffer, streams spike words into it, waits for the
// synapse/neuron passes, optionally launches STDP, and repeats for the programmed step count.
module snn_step_scheduler #(
    parameter int NUM_WORDS = 144,
    parameter int STEP_W    = 8,
    parameter int TMO_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [STEP_W-1:0] i_num_steps,
    input  logic              i_learn_en,
    input  logic              i_abort,
    output logic              o_b_run,
    output logic              o_spk_rd,
    input  logic              i_spk_vld,
    input  logic              i_pre_done,
    input  logic              i_post_done,
    output logic              o_stdp_run,
    input  logic              i_stdp_done,
    output logic [STEP_W-1:0] o_step,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);
    localparam int WCNT_W = $clog2(NUM_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_STRM, S_SYN, S_POST, S_STDP, S_NEXT, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic                learn_q, learn_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                b_run_q, b_run_d;
    logic                stdp_run_q, stdp_run_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [TMO_W-1:0]    tmo_inc;
    logic                wd_hit;
    logic                waiting;
    logic                spk_rd;

    assign spk_rd  = (state_q == S_STRM) && (wcnt_q < WCNT_W'(NUM_WORDS));
    assign tmo_inc = tmo_q + TMO_W'(1);
    // Timeout fires on the edge where the watchdog would reach all-ones.
    assign wd_hit  = (tmo_inc == {TMO_W{1'b1}});
    assign waiting = (state_q == S_SYN) || (state_q == S_POST) || (state_q == S_STDP);

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        step_d     = step_q;
        steps_d    = steps_q;
        learn_d    = learn_q;
        err_d      = err_q;
        b_run_d    = 1'b0;
        stdp_run_d = 1'b0;
        done_d     = 1'b0;
        tmo_d      = tmo_q;

        case (state_q)
            S_IDLE: if (i_start) begin
                state_d = S_ARM;
                steps_d = (i_num_steps == '0) ? STEP_W'(1) : i_num_steps;
                learn_d = i_learn_en;
                err_d   = 1'b0;
                step_d  = '0;
                wcnt_d  = '0;
                b_run_d = 1'b1;
            end
            S_ARM: state_d = S_STRM;
            S_STRM: if (i_spk_vld && spk_rd) begin
                wcnt_d = wcnt_q + WCNT_W'(1);
                if (wcnt_q == WCNT_W'(NUM_WORDS - 1)) state_d = S_SYN;
            end
            S_SYN: begin
                if (i_pre_done) state_d = S_POST;
                else if (wd_hit) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_POST: begin
                if (i_post_done) begin
                    if (learn_q) begin
                        state_d    = S_STDP;
                        stdp_run_d = 1'b1;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else if (wd_hit) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_STDP: begin
                if (i_stdp_done) state_d = S_NEXT;
                else if (wd_hit) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_NEXT: begin
                if (step_q == steps_q - STEP_W'(1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_ARM;
                    step_d  = step_q + STEP_W'(1);
                    wcnt_d  = '0;
                    b_run_d = 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        tmo_d = (waiting && state_d == state_q) ? tmo_inc : '0;

        // Abort overrides everything except the sticky error flag.
        if (i_abort) begin
            state_d    = S_IDLE;
            wcnt_d     = '0;
            step_d     = '0;
            tmo_d      = '0;
            err_d      = err_q;
            b_run_d    = 1'b0;
            stdp_run_d = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wcnt_q     <= '0;
            step_q     <= '0;
            steps_q    <= '0;
            learn_q    <= 1'b0;
            tmo_q      <= '0;
            b_run_q    <= 1'b0;
            stdp_run_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            step_q     <= step_d;
            steps_q    <= steps_d;
            learn_q    <= learn_d;
            tmo_q      <= tmo_d;
            b_run_q    <= b_run_d;
            stdp_run_q <= stdp_run_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign o_b_run    = b_run_q;
    assign o_spk_rd   = spk_rd;
    assign o_stdp_run = stdp_run_q;
    assign o_step     = step_q;
    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = done_q;
    assign o_err      = err_q;
endmodule

// File: tb/tb_snn_step_scheduler.sv
// Directed bench for snn_step_scheduler; watchdog shortened to 4 bits so timeouts are quick.
module tb_snn_step_scheduler;
    logic       clk = 0;
    logic       reset = 1;
    logic       i_start = 0, i_learn_en = 0, i_abort = 0;
    logic [7:0] i_num_steps = 0;
    logic       i_spk_vld = 0, i_pre_done = 0, i_post_done = 0, i_stdp_done = 0;
    logic       o_b_run, o_spk_rd, o_stdp_run, o_busy, o_done, o_err;
    logic [7:0] o_step;

    int checks = 0;
    int passed = 0;

    snn_step_scheduler #(.NUM_WORDS(144), .STEP_W(8), .TMO_W(4)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_num_steps(i_num_steps),
        .i_learn_en(i_learn_en), .i_abort(i_abort), .o_b_run(o_b_run), .o_spk_rd(o_spk_rd),
        .i_spk_vld(i_spk_vld), .i_pre_done(i_pre_done), .i_post_done(i_post_done),
        .o_stdp_run(o_stdp_run), .i_stdp_done(i_stdp_done), .o_step(o_step),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Event monitor sampled mid-cycle
    int b_run_cnt = 0, stdp_cnt = 0, done_cnt = 0, rd_cnt = 0, acc_cnt = 0, viol = 0;
    logic prev_b = 0, prev_s = 0, prev_d = 0;
    logic [7:0] step_log [0:63];
    always @(negedge clk) begin
        if (o_b_run) begin
            step_log[b_run_cnt[5:0]] <= o_step;
            b_run_cnt <= b_run_cnt + 1;
        end
        if (o_stdp_run) stdp_cnt <= stdp_cnt + 1;
        if (o_done) done_cnt <= done_cnt + 1;
        if (o_spk_rd) rd_cnt <= rd_cnt + 1;
        if (o_spk_rd && i_spk_vld) acc_cnt <= acc_cnt + 1;
        if ((o_b_run && prev_b) || (o_stdp_run && prev_s) || (o_done && prev_d)) viol <= viol + 1;
        prev_b <= o_b_run;
        prev_s <= o_stdp_run;
        prev_d <= o_done;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: sim time exceeded, checks %0d passed %0d", checks, passed);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_run(input logic [7:0] n, input logic learn);
        i_num_steps = n;
        i_learn_en  = learn;
        i_start     = 1;
        tick();
        i_start     = 0;
    endtask

    task automatic pulse_pre();
        i_pre_done = 1; tick(); i_pre_done = 0;
    endtask
    task automatic pulse_post();
        i_post_done = 1; tick(); i_post_done = 0;
    endtask
    task automatic pulse_stdp();
        i_stdp_done = 1; tick(); i_stdp_done = 0;
    endtask

    task automatic stream_all();
        bit seen;
        bit ended;
        seen = 0;
        ended = 0;
        i_spk_vld = 1;
        for (int i = 0; i < 400; i++) begin
            if (o_spk_rd) seen = 1;
            else if (seen) begin
                ended = 1;
                break;
            end
            tick();
        end
        i_spk_vld = 0;
        checks++; if (ended !== 1'b1) $display("FAIL stream_end: ended=%0b expected 1", ended); else passed++;
    endtask

    task automatic test_reset();
        wait_cycles(2);
        checks++; if (o_busy !== 1'b0) $display("FAIL rst_busy: got %0b expected 0", o_busy); else passed++;
        checks++; if ({o_b_run, o_spk_rd, o_stdp_run, o_done, o_err} !== 5'b0)
            $display("FAIL rst_outs: got %b expected 00000", {o_b_run, o_spk_rd, o_stdp_run, o_done, o_err}); else passed++;
        checks++; if (o_step !== 8'd0) $display("FAIL rst_step: got %0d expected 0", o_step); else passed++;
        @(negedge clk);
        reset = 0;
        tick();
    endtask

    task automatic test_single_step();
        int b0, s0, d0, r0, a0;
        b0 = b_run_cnt; s0 = stdp_cnt; d0 = done_cnt; r0 = rd_cnt; a0 = acc_cnt;
        start_run(8'd1, 1'b0);
        checks++; if (o_b_run !== 1'b1) $display("FAIL single_b_run: got %0b expected 1", o_b_run); else passed++;
        checks++; if (o_busy !== 1'b1) $display("FAIL single_busy: got %0b expected 1", o_busy); else passed++;
        i_spk_vld = 1;
        wait_cycles(147);
        i_spk_vld = 0;
        checks++; if (rd_cnt - r0 !== 144) $display("FAIL single_rd_cycles: got %0d expected 144", rd_cnt - r0); else passed++;
        checks++; if (acc_cnt - a0 !== 144) $display("FAIL single_words: got %0d expected 144", acc_cnt - a0); else passed++;
        checks++; if (o_spk_rd !== 1'b0) $display("FAIL single_rd_drop: got %0b expected 0", o_spk_rd); else passed++;
        wait_cycles(5);
        pulse_pre();
        wait_cycles(9);
        pulse_post();
        tick();
        checks++; if (o_done !== 1'b1) $display("FAIL single_done: got %0b expected 1", o_done); else passed++;
        tick();
        checks++; if (o_busy !== 1'b0) $display("FAIL single_idle: got %0b expected 0", o_busy); else passed++;
        checks++; if (done_cnt - d0 !== 1) $display("FAIL single_done_cnt: got %0d expected 1", done_cnt - d0); else passed++;
        checks++; if (stdp_cnt - s0 !== 0) $display("FAIL single_stdp_cnt: got %0d expected 0", stdp_cnt - s0); else passed++;
        checks++; if (b_run_cnt - b0 !== 1) $display("FAIL single_b_run_cnt: got %0d expected 1", b_run_cnt - b0); else passed++;
        checks++; if (o_step !== 8'd0) $display("FAIL single_step: got %0d expected 0", o_step); else passed++;
    endtask

    task automatic test_three_steps_learn();
        int b0, s0, d0;
        b0 = b_run_cnt; s0 = stdp_cnt; d0 = done_cnt;
        start_run(8'd3, 1'b1);
        for (int s = 0; s < 3; s++) begin
            stream_all();
            wait_cycles(3);
            pulse_pre();
            wait_cycles(3);
            pulse_post();
            checks++; if (o_stdp_run !== 1'b1) $display("FAIL learn_stdp_run step%0d: got %0b expected 1", s, o_stdp_run); else passed++;
            if (s < 2) begin
                wait_cycles(4);
                pulse_stdp();
            end else begin
                pulse_stdp();
                checks++; if (o_done !== 1'b0) $display("FAIL learn_done_early: got %0b expected 0", o_done); else passed++;
                tick();
                checks++; if (o_done !== 1'b1) $display("FAIL learn_done_lat: got %0b expected 1", o_done); else passed++;
            end
        end
        tick();
        checks++; if (b_run_cnt - b0 !== 3) $display("FAIL learn_b_run_cnt: got %0d expected 3", b_run_cnt - b0); else passed++;
        checks++; if (stdp_cnt - s0 !== 3) $display("FAIL learn_stdp_cnt: got %0d expected 3", stdp_cnt - s0); else passed++;
        checks++; if (done_cnt - d0 !== 1) $display("FAIL learn_done_cnt: got %0d expected 1", done_cnt - d0); else passed++;
        for (int k = 0; k < 3; k++) begin
            checks++; if (step_log[(b0 + k) % 64] !== 8'(k))
                $display("FAIL learn_step_seq[%0d]: got %0d expected %0d", k, step_log[(b0 + k) % 64], k); else passed++;
        end
        checks++; if (o_step !== 8'd2) $display("FAIL learn_final_step: got %0d expected 2", o_step); else passed++;
    endtask

    task automatic test_stall();
        int r0, a0, d0;
        r0 = rd_cnt; a0 = acc_cnt; d0 = done_cnt;
        start_run(8'd1, 1'b0);
        for (int i = 0; i < 296; i++) begin
            i_spk_vld = (i % 2 == 0);
            tick();
        end
        i_spk_vld = 0;
        checks++; if (rd_cnt - r0 !== 288) $display("FAIL stall_rd_cycles: got %0d expected 288", rd_cnt - r0); else passed++;
        checks++; if (acc_cnt - a0 !== 144) $display("FAIL stall_words: got %0d expected 144", acc_cnt - a0); else passed++;
        pulse_pre();
        pulse_post();
        tick();
        tick();
        checks++; if (done_cnt - d0 !== 1) $display("FAIL stall_done_cnt: got %0d expected 1", done_cnt - d0); else passed++;
    endtask

    task automatic test_watchdog();
        int d0, err_k;
        d0 = done_cnt; err_k = -1;
        start_run(8'd1, 1'b0);
        stream_all();
        pulse_pre();
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (o_err && err_k < 0) err_k = k;
        end
        checks++; if (err_k !== 15) $display("FAIL wd_latency: got %0d expected 15", err_k); else passed++;
        checks++; if (o_busy !== 1'b0) $display("FAIL wd_idle: got %0b expected 0", o_busy); else passed++;
        checks++; if (done_cnt - d0 !== 0) $display("FAIL wd_no_done: got %0d expected 0", done_cnt - d0); else passed++;
        start_run(8'd1, 1'b0);
        checks++; if (o_err !== 1'b0) $display("FAIL wd_err_clear: got %0b expected 0", o_err); else passed++;
        i_abort = 1; tick(); i_abort = 0;
    endtask

    task automatic test_abort();
        int a0, d0;
        bit hit;
        hit = 0;
        a0 = acc_cnt; d0 = done_cnt;
        start_run(8'd1, 1'b0);
        i_spk_vld = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (acc_cnt - a0 == 50) begin
                hit = 1;
                break;
            end
        end
        checks++; if (hit !== 1'b1) $display("FAIL abort_reach50: got %0b expected 1", hit); else passed++;
        i_abort = 1; tick(); i_abort = 0;
        i_spk_vld = 0;
        checks++; if (o_busy !== 1'b0) $display("FAIL abort_idle: got %0b expected 0", o_busy); else passed++;
        checks++; if (o_spk_rd !== 1'b0) $display("FAIL abort_rd: got %0b expected 0", o_spk_rd); else passed++;
        wait_cycles(3);
        checks++; if (done_cnt - d0 !== 0) $display("FAIL abort_no_done: got %0d expected 0", done_cnt - d0); else passed++;
        a0 = acc_cnt;
        start_run(8'd1, 1'b0);
        stream_all();
        checks++; if (acc_cnt - a0 !== 144) $display("FAIL abort_rerun_words: got %0d expected 144", acc_cnt - a0); else passed++;
        pulse_pre();
        pulse_post();
        tick();
        tick();
        checks++; if (done_cnt - d0 !== 1) $display("FAIL abort_rerun_done: got %0d expected 1", done_cnt - d0); else passed++;
        i_start = 1; i_abort = 1; tick(); i_start = 0; i_abort = 0;
        checks++; if (o_busy !== 1'b0) $display("FAIL abort_start_idle: got %0b expected 0", o_busy); else passed++;
    endtask

    task automatic test_edge_cases();
        int b0, d0;
        b0 = b_run_cnt; d0 = done_cnt;
        start_run(8'd0, 1'b0);
        i_spk_vld = 1;
        tick();
        i_num_steps = 8'd5;
        i_start = 1; tick(); i_start = 0;
        i_pre_done = 1; tick(); i_pre_done = 0;
        stream_all();
        wait_cycles(5);
        checks++; if (o_busy !== 1'b1) $display("FAIL edge_syn_wait: got %0b expected 1", o_busy); else passed++;
        pulse_pre();
        wait_cycles(2);
        pulse_post();
        tick();
        checks++; if (o_done !== 1'b1) $display("FAIL edge_zero_steps_done: got %0b expected 1", o_done); else passed++;
        checks++; if (o_step !== 8'd0) $display("FAIL edge_step: got %0d expected 0", o_step); else passed++;
        tick();
        checks++; if (o_busy !== 1'b0) $display("FAIL edge_idle: got %0b expected 0", o_busy); else passed++;
        checks++; if (b_run_cnt - b0 !== 1) $display("FAIL edge_b_run_cnt: got %0d expected 1", b_run_cnt - b0); else passed++;
        checks++; if (done_cnt - d0 !== 1) $display("FAIL edge_done_cnt: got %0d expected 1", done_cnt - d0); else passed++;
    endtask

    task automatic test_reset_midrun();
        start_run(8'd2, 1'b0);
        stream_all();
        pulse_pre();
        pulse_post();
        tick();
        checks++; if (o_step !== 8'd1) $display("FAIL mid_step1: got %0d expected 1", o_step); else passed++;
        i_spk_vld = 1;
        wait_cycles(10);
        reset = 1;
        #1;
        checks++; if (o_busy !== 1'b0 || o_spk_rd !== 1'b0)
            $display("FAIL mid_reset_idle: busy=%0b rd=%0b expected 0 0", o_busy, o_spk_rd); else passed++;
        checks++; if (o_step !== 8'd0) $display("FAIL mid_reset_step: got %0d expected 0", o_step); else passed++;
        i_spk_vld = 0;
        tick();
        reset = 0;
        tick();
    endtask

    task automatic test_pulse_hygiene();
        checks++; if (viol !== 0) $display("FAIL pulse_back_to_back: got %0d expected 0", viol); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_three_steps_learn();
        test_stall();
        test_watchdog();
        test_abort();
        test_edge_cases();
        test_reset_midrun();
        test_pulse_hygiene();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
